// File: rtl/ula_wb_stage.sv
// ---------------------------------------------------------------------------
// ula_wb_stage
//
// Purpose: writeback/commit stage directly after the logic ALU. Each ALU
// result is queued with its opcode, flags and destination address in a small
// in-order buffer. The head entry is offered to the register-file write port.
// When that write retires, the architectural flag register {O,C,S,Z} is
// updated according to the opcode class of the retiring entry.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer must hold its payload until it sees ready. Once
// wr_valid is raised, wr_addr/wr_data stay stable until wr_ready is seen.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   in_valid / in_ready          ALU result handshake (in_ready = !full)
//   in_op, in_resu, in_o/c/s/z,
//   in_dest                      ALU result payload
//   flush                        synchronous discard of all buffered entries
//   wr_valid / wr_ready          register-file write handshake
//   wr_addr, wr_data             head entry address / data
//   flags                        architectural flags {O,C,S,Z}
//   count                        buffer occupancy
//
// Optional feature: define ULA_WB_BYPASS_EN to forward an input straight to
// the write port when the buffer is empty and the register file is ready.
// Without it, the minimum latency is one cycle.
// ---------------------------------------------------------------------------
module ula_wb_stage #(
    parameter int DEPTH = 2,
    parameter int DW    = 3,
    parameter int AW    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_op,
    input  logic [DW-1:0]            in_resu,
    input  logic                     in_o,
    input  logic                     in_c,
    input  logic                     in_s,
    input  logic                     in_z,
    input  logic [AW-1:0]            in_dest,
    input  logic                     flush,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [AW-1:0]            wr_addr,
    output logic [DW-1:0]            wr_data,
    output logic [3:0]               flags,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    // Buffer storage; needs no reset because the pointers define validity.
    logic [4:0]    r_op   [DEPTH];
    logic [DW-1:0] r_resu [DEPTH];
    logic [3:0]    r_flg  [DEPTH];
    logic [AW-1:0] r_dest [DEPTH];

    // Each pointer has one extra MSB so that full and empty can be told apart.
    logic [PW:0]   r_wr_ptr;
    logic [PW:0]   r_rd_ptr;
    logic [3:0]    r_flags;

    logic          w_empty;
    logic          w_full;
    logic          w_bypass;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_head;

    // Applies the flag-update rule for one retiring opcode. Flag bits that
    // the rule does not name keep their previous value.
    function automatic logic [3:0] f_next_flags(input logic [4:0] op,
                                                input logic [3:0] old_f,
                                                input logic [3:0] new_f);
        if (op == 5'b10011 || op == 5'b11111)
            return old_f;
        else if (op == 5'b10000)
            return {old_f[3:1], new_f[0]};
        else if (op == 5'b01000 || op == 5'b01001)
            return {old_f[3], new_f[2:0]};
        else if (op >= 5'b10001 && op <= 5'b11110)
            return {old_f[3:2], new_f[1:0]};
        else
            return new_f;
    endfunction

    assign w_head  = r_rd_ptr[PW-1:0];
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]) &&
                     (r_wr_ptr[PW] != r_rd_ptr[PW]);

`ifdef ULA_WB_BYPASS_EN
    // An input that meets an empty buffer and a ready register file goes
    // straight through. A flush in the same cycle blocks it.
    assign w_bypass = w_empty & in_valid & wr_ready & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    // When the buffer is full, no push happens even if a pop happens in the
    // same cycle. The producer retries once it sees in_ready again.
    assign w_push   = in_valid & ~w_full & ~flush & ~w_bypass;
    assign w_pop    = ~w_empty & wr_ready & ~flush;

    assign in_ready = ~w_full;
    assign wr_valid = ~w_empty | w_bypass;
    assign wr_addr  = w_bypass ? in_dest : (w_empty ? '0 : r_dest[w_head]);
    assign wr_data  = w_bypass ? in_resu : (w_empty ? '0 : r_resu[w_head]);
    assign flags    = r_flags;
    assign count    = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op  [r_wr_ptr[PW-1:0]] <= in_op;
            r_resu[r_wr_ptr[PW-1:0]] <= in_resu;
            r_flg [r_wr_ptr[PW-1:0]] <= {in_o, in_c, in_s, in_z};
            r_dest[r_wr_ptr[PW-1:0]] <= in_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_flags  <= 4'b0000;
        end else if (flush) begin
            // Flush drops the buffer but leaves the flags untouched.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
                r_flags  <= f_next_flags(r_op[w_head], r_flags, r_flg[w_head]);
            end else if (w_bypass) begin
                r_flags  <= f_next_flags(in_op, r_flags,
                                         {in_o, in_c, in_s, in_z});
            end
        end
    end

endmodule

// File: tb/tb_ula_wb_stage.sv
module tb_ula_wb_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_op = '0;
  logic [2:0] in_resu = '0;
  logic       in_o = 1'b0, in_c = 1'b0, in_s = 1'b0, in_z = 1'b0;
  logic [2:0] in_dest = '0;
  logic       flush = 1'b0;
  logic       wr_valid;
  logic       wr_ready = 1'b0;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic [3:0] flags;
  logic [1:0] count;

  int n_tests = 0;
  int n_fail = 0;

  logic [5:0] exp_q[$];

  ula_wb_stage #(.DEPTH(2), .DW(3), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_resu(in_resu),
    .in_o(in_o), .in_c(in_c), .in_s(in_s), .in_z(in_z),
    .in_dest(in_dest), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .flags(flags), .count(count)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    int iv; int op; int resu; int fin; int dest; int wrr; int fl;
    int ewv; int ewa; int ewd; int eflags; int ecnt; int eir;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid = v.iv[0];
    in_op    = 5'(v.op);
    in_resu  = 3'(v.resu);
    {in_o, in_c, in_s, in_z} = 4'(v.fin);
    in_dest  = 3'(v.dest);
    wr_ready = v.wrr[0];
    flush    = v.fl[0];
  endtask

  initial begin
    //            iv op        resu fin      dest wrr fl  wv wa wd flags    cnt ir
    vecs[0]  = '{1, 'b10001, 0, 'b0001, 5, 1, 0,  1, 5, 0, 'b0000, 1, 1};
    vecs[1]  = '{0, 0,       0, 0,      0, 1, 0,  0, 0, 0, 'b0001, 0, 1};
    vecs[2]  = '{1, 'b00000, 7, 'b1000, 1, 0, 0,  1, 1, 7, 'b0001, 1, 1};
    vecs[3]  = '{0, 0,       0, 0,      0, 1, 0,  0, 0, 0, 'b1000, 0, 1};
    vecs[4]  = '{1, 'b01000, 6, 'b0110, 2, 0, 0,  1, 2, 6, 'b1000, 1, 1};
    vecs[5]  = '{1, 'b10011, 2, 'b0001, 3, 1, 0,  1, 3, 2, 'b1110, 1, 1};
    vecs[6]  = '{0, 0,       0, 0,      0, 1, 0,  0, 0, 0, 'b1110, 0, 1};
    vecs[7]  = '{1, 'b10000, 1, 'b1111, 4, 0, 0,  1, 4, 1, 'b1110, 1, 1};
    vecs[8]  = '{1, 'b00001, 5, 'b0100, 6, 0, 0,  1, 4, 1, 'b1110, 2, 0};
    vecs[9]  = '{1, 'b10010, 3, 'b1010, 7, 0, 0,  1, 4, 1, 'b1110, 2, 0};
    vecs[10] = '{1, 'b10010, 3, 'b1010, 7, 1, 0,  1, 6, 5, 'b1111, 1, 1};
    vecs[11] = '{1, 'b10010, 3, 'b1010, 7, 0, 0,  1, 6, 5, 'b1111, 2, 0};
    vecs[12] = '{0, 0,       0, 0,      0, 1, 0,  1, 7, 3, 'b0100, 1, 1};
    vecs[13] = '{0, 0,       0, 0,      0, 1, 0,  0, 0, 0, 'b0110, 0, 1};
    vecs[14] = '{1, 'b00010, 2, 'b0000, 1, 0, 0,  1, 1, 2, 'b0110, 1, 1};
    vecs[15] = '{1, 'b00011, 3, 'b1111, 2, 0, 0,  1, 1, 2, 'b0110, 2, 0};
    vecs[16] = '{1, 'b00000, 0, 'b1001, 3, 1, 1,  0, 0, 0, 'b0110, 0, 1};
    vecs[17] = '{0, 0,       0, 0,      0, 1, 0,  0, 0, 0, 'b0110, 0, 1};

    // reset
    #12 rst_n = 1'b1;
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_flags", flags, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);

    // table vectors: apply on negedge, check just after the following posedge
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wr_valid", i), wr_valid, vecs[i].ewv);
      if (vecs[i].ewv != 0) begin
        chk($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].ewa);
        chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].ewd);
      end
      chk($sformatf("v%0d_flags", i), flags, vecs[i].eflags);
      chk($sformatf("v%0d_count", i), count, vecs[i].ecnt);
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].eir);
    end

    // stream 8 entries through the buffer, with stalls, across the pointer wrap
    begin
      int pushed = 0;
      int popped = 0;
      for (int cyc = 0; cyc < 200 && popped < 8; cyc++) begin
        @(negedge clk);
        flush    = 1'b0;
        in_valid = (pushed < 8);
        in_op    = 5'b10011;
        in_dest  = 3'(pushed);
        in_resu  = ~3'(pushed);
        {in_o, in_c, in_s, in_z} = 4'b1111;
        wr_ready = (cyc >= 3) && (cyc % 4 != 1);
        #1;
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            chk("stream_unexpected_pop", 1, 0);
          end else begin
            chk($sformatf("stream%0d_addr", popped), wr_addr, exp_q[0][5:3]);
            chk($sformatf("stream%0d_data", popped), wr_data, exp_q[0][2:0]);
            void'(exp_q.pop_front());
          end
          popped++;
        end
        if (in_valid && in_ready) begin
          exp_q.push_back({in_dest, in_resu});
          pushed++;
        end
      end
      chk("stream_popped", popped, 8);
      @(negedge clk);
      in_valid = 1'b0;
      wr_ready = 1'b0;
      #1;
      chk("stream_empty_count", count, 0);
      chk("stream_flags_kept", flags, 'b0110);
    end

    // asynchronous reset with one entry pending
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 5'b00000;
    in_dest  = 3'd5;
    in_resu  = 3'd4;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_count", count, 1);
    chk("pre_rst_wr_valid", wr_valid, 1);
    chk("pre_rst_flags", flags, 'b0110);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_wr_valid", wr_valid, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_flags", flags, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
